// File: rtl/frame_sequencer.sv
// ---------------------------------------------------------------------------
// frame_sequencer
//
// Purpose:
//   Streams one frame of ROW x COL pixels from an upstream valid/ready port
//   to a registered downstream valid/ready port. Each outgoing pixel carries
//   its column/row position and start-of-frame / end-of-line / end-of-frame
//   markers. A frame is launched by a single-cycle start request. When the
//   last pixel has been accepted downstream, frame_done pulses for one cycle.
//
// Optional feature (macro LINE_GAP_EN):
//   When defined, H_GAP idle cycles (s_ready held low) are inserted after
//   every line except the last one. When undefined, lines stream back to
//   back and H_GAP is unused.
//
// Parameters:
//   DATA_WIDTH  pixel width in bits
//   ROW         lines per frame   (2..1024)
//   COL         pixels per line   (2..1024)
//   H_GAP       idle cycles between lines (1..255), LINE_GAP_EN only
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   start                 frame start request (ignored while busy)
//   busy                  high from frame start until frame_done
//   frame_done            one-cycle pulse as the last pixel leaves
//   s_valid/s_ready/s_data  upstream pixel handshake
//   m_valid/m_ready/m_data  downstream registered pixel handshake
//   m_col, m_row          position of m_data
//   m_sof, m_eol, m_eof   first pixel, last column, last pixel markers
// ---------------------------------------------------------------------------
module frame_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int ROW        = 480,
  parameter int COL        = 640,
  parameter int H_GAP      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  frame_done,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [9:0]            m_col,
  output logic [9:0]            m_row,
  output logic                  m_sof,
  output logic                  m_eol,
  output logic                  m_eof
);

  localparam logic [9:0] LastCol = 10'(COL - 1);
  localparam logic [9:0] LastRow = 10'(ROW - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    GAP,
    DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [9:0] col_q, col_d;
  logic [9:0] row_q, row_d;

  logic                  mValid_q;
  logic [DATA_WIDTH-1:0] mData_q;
  logic [9:0]            mCol_q;
  logic [9:0]            mRow_q;
  logic                  mSof_q;
  logic                  mEol_q;
  logic                  mEof_q;

  logic xfer;
  logic atLastCol;
  logic atLastRow;

`ifdef LINE_GAP_EN
  logic [7:0] gap_q, gap_d;
`else
  logic unusedHGap;
  assign unusedHGap = |H_GAP;
`endif

  assign atLastCol = (col_q == LastCol);
  assign atLastRow = (row_q == LastRow);

  // Status and upstream ready are decoded straight from the state so that
  // a downstream pop frees the output register in the same cycle.
  always_comb begin
    busy       = (state_q != IDLE);
    s_ready    = (state_q == ACTIVE) && (!mValid_q || m_ready);
    frame_done = (state_q == DRAIN) && mValid_q && m_ready;
  end

  assign xfer = s_ready && s_valid;

  // Next-state and position counter logic. The row counter saturates at the
  // last row; counters are re-zeroed whenever a new frame is launched.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
`ifdef LINE_GAP_EN
    gap_d   = gap_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACTIVE;
          col_d   = '0;
          row_d   = '0;
        end
      end
      ACTIVE: begin
        if (xfer) begin
          if (atLastCol) begin
            col_d = '0;
            if (!atLastRow) begin
              row_d = row_q + 10'd1;
            end
          end else begin
            col_d = col_q + 10'd1;
          end
          if (atLastCol && atLastRow) begin
            state_d = DRAIN;
          end
`ifdef LINE_GAP_EN
          else if (atLastCol) begin
            // Loaded with H_GAP-1 so GAP lasts exactly H_GAP cycles.
            state_d = GAP;
            gap_d   = 8'(H_GAP - 1);
          end
`endif
        end
      end
      GAP: begin
`ifdef LINE_GAP_EN
        if (gap_q == 8'd0) begin
          state_d = ACTIVE;
        end else begin
          gap_d = gap_q - 8'd1;
        end
`else
        state_d = ACTIVE;
`endif
      end
      DRAIN: begin
        if (mValid_q && m_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

`ifdef LINE_GAP_EN
  // Inter-line idle down-counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_d;
    end
  end
`endif

  // Output register: loads on every upstream transfer, otherwise holds its
  // contents and only drops valid once the downstream side has taken it.
  always_ff @(posedge clk) begin
    if (rst) begin
      mValid_q <= 1'b0;
      mData_q  <= '0;
      mCol_q   <= '0;
      mRow_q   <= '0;
      mSof_q   <= 1'b0;
      mEol_q   <= 1'b0;
      mEof_q   <= 1'b0;
    end else if (xfer) begin
      mValid_q <= 1'b1;
      mData_q  <= s_data;
      mCol_q   <= col_q;
      mRow_q   <= row_q;
      mSof_q   <= (col_q == 10'd0) && (row_q == 10'd0);
      mEol_q   <= atLastCol;
      mEof_q   <= atLastCol && atLastRow;
    end else if (m_ready) begin
      mValid_q <= 1'b0;
    end
  end

  assign m_valid = mValid_q;
  assign m_data  = mData_q;
  assign m_col   = mCol_q;
  assign m_row   = mRow_q;
  assign m_sof   = mSof_q;
  assign m_eol   = mEol_q;
  assign m_eof   = mEof_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_frame_sequencer
//
// Self-checking bench for frame_sequencer (ROW=4, COL=8, H_GAP=3). A
// pixel-index model predicts every handshake output each cycle; directed
// frames pin frame timing, marker counts and ordering with literal values,
// then a randomized phase stresses the handshakes. Follows LINE_GAP_EN.
// ---------------------------------------------------------------------------
module tb_frame_sequencer;

  localparam int DW    = 8;
  localparam int ROW   = 4;
  localparam int COL   = 8;
  localparam int H_GAP = 3;
  localparam int NPIX  = ROW * COL;
`ifdef LINE_GAP_EN
  localparam int GapCycles = (ROW - 1) * H_GAP;
`else
  localparam int GapCycles = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          s_valid = 1'b0;
  logic          m_ready = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          busy, frame_done, s_ready, m_valid;
  logic [DW-1:0] m_data;
  logic [9:0]    m_col, m_row;
  logic          m_sof, m_eol, m_eof;

  always #5 clk = ~clk;

  frame_sequencer #(
    .DATA_WIDTH(DW), .ROW(ROW), .COL(COL), .H_GAP(H_GAP)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .frame_done(frame_done),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_col(m_col), .m_row(m_row), .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof)
  );

  int checkCount = 0;
  int passCount  = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, actual, expected, $time);
  endtask

  // Behavioural model: frame progress as a count of accepted pixels, a
  // one-deep output slot holding pixel index + data, and remaining gap time.
  bit            mInFrame  = 0;
  int            mAccepted = 0;
  bit            mOutFull  = 0;
  logic [DW-1:0] mOutData  = '0;
  int            mOutIdx   = 0;
  int            mGapLeft  = 0;

  function automatic bit expSReady(input logic mr);
    return mInFrame && (mAccepted < NPIX) && (mGapLeft == 0) && (!mOutFull || mr);
  endfunction

  function automatic bit expFrameDone(input logic mr);
    return mInFrame && (mAccepted == NPIX) && mOutFull && mr;
  endfunction

  task automatic modelStep();
    bit doXfer, doDone;
    if (rst) begin
      mInFrame = 0; mAccepted = 0; mOutFull = 0;
      mOutData = '0; mOutIdx = 0; mGapLeft = 0;
    end else begin
      doXfer = expSReady(m_ready) && s_valid;
      doDone = expFrameDone(m_ready);
      if (mGapLeft > 0) mGapLeft--;
      if (doXfer) begin
        mOutData = s_data;
        mOutIdx  = mAccepted;
        mOutFull = 1;
        mAccepted++;
`ifdef LINE_GAP_EN
        if ((mAccepted % COL == 0) && (mAccepted < NPIX)) mGapLeft = H_GAP;
`endif
      end else if (m_ready) begin
        mOutFull = 0;
      end
      if (doDone) mInFrame = 0;
      else if (!mInFrame && start) begin
        mInFrame  = 1;
        mAccepted = 0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    modelStep();
  end

  // Per-cycle comparison against the model, half a period after the edge.
  initial forever begin
    @(negedge clk);
    checkOutput("busy", busy, mInFrame);
    checkOutput("s_ready", s_ready, expSReady(m_ready));
    checkOutput("frame_done", frame_done, expFrameDone(m_ready));
    checkOutput("m_valid", m_valid, mOutFull);
    if (mOutFull) begin
      checkOutput("m_data", m_data, mOutData);
      checkOutput("m_col", m_col, 32'(mOutIdx % COL));
      checkOutput("m_row", m_row, 32'(mOutIdx / COL));
      checkOutput("m_sof", m_sof, mOutIdx == 0);
      checkOutput("m_eol", m_eol, (mOutIdx % COL) == COL - 1);
      checkOutput("m_eof", m_eof, mOutIdx == NPIX - 1);
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before 1ms");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic st, input logic sv,
                               input logic mr, input logic [DW-1:0] d);
    rst = r; start = st; s_valid = sv; m_ready = mr; s_data = d;
  endtask

  logic [DW-1:0] outQ[$];
  int sofCnt, eolCnt, eofCnt, rfLow, rfCycle;
  logic rfFirstSof;

  // Runs one frame from a start pulse with s_valid held high; data is the
  // pixel index. Optionally toggles m_ready and pokes start mid-frame and in
  // the frame_done cycle. Leaves the caller just after a rising edge.
  task automatic runFrame(input bit toggleReady, input bit pokeStart);
    logic mr, st;
    outQ.delete();
    sofCnt = 0; eolCnt = 0; eofCnt = 0; rfLow = 0; rfCycle = -1; rfFirstSof = 1'b0;
    for (int cyc = 0; cyc < 600 && rfCycle < 0; cyc++) begin
      mr = toggleReady ? logic'(cyc % 2 == 0) : 1'b1;
      st = (cyc == 0) || (pokeStart && ((mInFrame && mAccepted == 11) || expFrameDone(mr)));
      applyStimulus(1'b0, st, 1'b1, mr, DW'(mAccepted));
      @(negedge clk);
      if (m_valid && m_ready) begin
        if (outQ.size() == 0) rfFirstSof = m_sof;
        outQ.push_back(m_data);
        sofCnt += int'(m_sof);
        eolCnt += int'(m_eol);
        eofCnt += int'(m_eof);
      end
      if (busy && !s_ready) rfLow++;
      if (frame_done) rfCycle = cyc;
      stepEdge();
    end
    if (rfCycle < 0) checkOutput("frameTimeout", 1, 0);
  endtask

  function automatic int orderErrors();
    int errs = 0;
    foreach (outQ[i]) if (outQ[i] != DW'(i)) errs++;
    return errs;
  endfunction

  initial begin
    int busyAfter;
    int randFrames;
    bit reached;

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
    stepEdge();
    stepEdge();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0);
    @(negedge clk);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstSReady", s_ready, 0);
    checkOutput("rstMValid", m_valid, 0);
    checkOutput("rstFrameDone", frame_done, 0);
    checkOutput("rstMData", m_data, 0);
    checkOutput("rstMCol", m_col, 0);
    checkOutput("rstMRow", m_row, 0);
    checkOutput("rstFlags", {m_sof, m_eol, m_eof}, 0);
    stepEdge();

    $display("[TB] full-rate frame");
    runFrame(1'b0, 1'b0);
    checkOutput("fullDoneCycle", rfCycle, NPIX + 1 + GapCycles);
    checkOutput("fullCount", outQ.size(), NPIX);
    checkOutput("fullOrder", orderErrors(), 0);
    checkOutput("fullSofCount", sofCnt, 1);
    checkOutput("fullEolCount", eolCnt, ROW);
    checkOutput("fullEofCount", eofCnt, 1);
    checkOutput("fullFirstSof", rfFirstSof, 1);
    checkOutput("fullReadyLow", rfLow, GapCycles + 1);
    checkOutput("modelAccepted", mAccepted, NPIX);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0);
    repeat (3) stepEdge();

    $display("[TB] toggled m_ready frame");
    runFrame(1'b1, 1'b0);
    checkOutput("toggleCount", outQ.size(), NPIX);
    checkOutput("toggleOrder", orderErrors(), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0);
    repeat (3) stepEdge();

    $display("[TB] reset mid-frame at (2,5), start held during reset");
    reached = 0;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, '0);
    for (int i = 0; i < 100 && !reached; i++) begin
      stepEdge();
      if (mAccepted == 2 * COL + 5) reached = 1;
      else applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, DW'(mAccepted));
    end
    checkOutput("reachedPixel25", reached, 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, DW'(mAccepted));
    stepEdge();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0);
    @(negedge clk);
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstMValid", m_valid, 0);
    checkOutput("midRstFrameDone", frame_done, 0);
    stepEdge();
    runFrame(1'b0, 1'b0);
    checkOutput("restartFirstSof", rfFirstSof, 1);
    checkOutput("restartFirstData", (outQ.size() > 0) ? 32'(outQ[0]) : 32'hFFFF, 0);
    checkOutput("restartDoneCycle", rfCycle, NPIX + 1 + GapCycles);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0);
    repeat (3) stepEdge();

    $display("[TB] start pulses at (1,3) and in frame_done cycle");
    runFrame(1'b0, 1'b1);
    checkOutput("pokeDoneCycle", rfCycle, NPIX + 1 + GapCycles);
    checkOutput("pokeCount", outQ.size(), NPIX);
    checkOutput("pokeOrder", orderErrors(), 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, '0);
    busyAfter = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      busyAfter += int'(busy);
      stepEdge();
    end
    checkOutput("pokeNoSecondFrame", busyAfter, 0);

    $display("[TB] randomized traffic");
    randFrames = 0;
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 399) == 0, $urandom_range(0, 15) == 0,
                    $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, DW'($urandom));
      @(negedge clk);
      if (frame_done) randFrames++;
      stepEdge();
    end
    $display("[TB] random phase completed %0d frames", randFrames);
    checkOutput("randFramesSeen", randFrames > 0, 1);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0);
    stepEdge();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/frame_sequencer.md
FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, pixel data width in bits.
REQ-002 Parameter ROW, default 480, lines per frame, range 2..1024.
REQ-003 Parameter COL, default 640, pixels per line, range 2..1024.
REQ-004 Parameter H_GAP, default 16, idle cycles inserted between lines, range 1..255.
REQ-005 The block SHALL provide these ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle frame start request.
- busy  out  1  high from frame start until frame_done.
- frame_done  out  1  single-cycle pulse when the last frame pixel leaves the output.
- s_valid  in  1  upstream pixel valid.
- s_ready  out  1  upstream ready.
- s_data  in  DATA_WIDTH  upstream pixel.
- m_valid  out  1  downstream pixel valid.
- m_ready  in  1  downstream ready.
- m_data  out  DATA_WIDTH  registered pixel.
- m_col  out  10  column of m_data.
- m_row  out  10  row of m_data.
- m_sof  out  1  m_data is pixel (0,0).
- m_eol  out  1  m_data is column COL-1.
- m_eof  out  1  m_data is pixel (ROW-1,COL-1).

Function
REQ-006 The FSM SHALL have states IDLE, ACTIVE, GAP and DRAIN.
REQ-007 IDLE: s_ready=0, busy=0; start=1 -> ACTIVE next cycle, col/row counters 0.
REQ-008 ACTIVE: s_ready SHALL equal (!m_valid || m_ready); a transfer occurs when s_valid && s_ready.
REQ-009 On a transfer, m_data/m_col/m_row/m_sof/m_eol/m_eof SHALL load from s_data and the current counters, and m_valid SHALL be 1 the next cycle (latency 1 cycle).
REQ-010 m_valid SHALL stay high and all m_* outputs SHALL hold stable until m_ready=1; m_valid clears on m_ready without a new transfer.
REQ-011 Column counter SHALL increment per transfer and wrap COL-1 -> 0; row counter SHALL increment on that wrap, never exceeding ROW-1.
REQ-012 Transfer at column COL-1 with row < ROW-1 -> GAP (LINE_GAP_EN defined) or stay ACTIVE (undefined).
REQ-013 GAP: s_ready=0 for exactly H_GAP cycles from a down-counter, then ACTIVE; m_valid/m_ready handshake continues during GAP.
REQ-014 Transfer at (ROW-1, COL-1) -> DRAIN; s_ready=0 in DRAIN.
REQ-015 DRAIN: in the cycle m_valid && m_ready, frame_done SHALL be 1 for one cycle and FSM -> IDLE.
REQ-016 start while busy=1 SHALL be ignored; start in the cycle frame_done is asserted SHALL be ignored.
REQ-017 busy SHALL be 1 in ACTIVE, GAP and DRAIN.
REQ-018 Upstream stall (s_valid=0) in ACTIVE SHALL not advance counters or change state.

Reset
REQ-019 On rst=1, next cycle: FSM IDLE; busy, frame_done, s_ready, m_valid, m_sof, m_eol, m_eof = 0; m_data, m_col, m_row, counters, gap counter = 0.
REQ-020 rst mid-frame SHALL abandon the frame without asserting frame_done; rst SHALL override start.

Configuration
REQ-021 Macro LINE_GAP_EN: defined -> GAP state and H_GAP counter present per REQ-012/013; undefined -> GAP logic absent, line end stays ACTIVE, H_GAP unused, continuous streaming.

Verification
REQ-022 ROW=4, COL=8, s_valid=m_ready=1, macro undefined: start -> 32 pixels on consecutive cycles, m_sof on first, m_eol at m_col=7, m_eof at (3,7), frame_done 1 cycle after last transfer.
REQ-023 LINE_GAP_EN, H_GAP=3, ROW=4, COL=8: s_ready low exactly 3 cycles after each of the first 3 line ends, no gap after row 3.
REQ-024 m_ready toggled 1010..: m_data/m_col/m_row held while m_valid && !m_ready; no pixel lost or duplicated; sequence 0..31 in order.
REQ-025 rst asserted at pixel (2,5): next cycle busy=0, m_valid=0, no frame_done; new start restarts at (0,0) with m_sof=1.
REQ-026 start pulsed at pixel (1,3) and in the frame_done cycle: counters unaffected, no second frame begins.
